// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Forwarding selects, load encoding and mult/div sequencer states.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   localparam logic [1:0] REGDATA_MEM = 2'b01;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } muldiv_state_t;

   function automatic fwd_sel_t fwd_sel(
      input logic [3:0] rs,
      input logic       mwe,
      input logic [3:0] madd,
      input logic       wwe,
      input logic [3:0] wadd
   );
      fwd_sel_t sel;
      sel = FWD_RF;
      if (rs != 4'd0) begin
         if (mwe && madd == rs)
            sel = FWD_M;
         else if (wwe && wadd == rs)
            sel = FWD_W;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_controller_muldiv_sequencer.sv
// Mult/div busy sequencer: counts down the unit latency,
// then strobes the hi/lo write for one cycle.
module muldiv_sequencer
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 16,
   parameter int CNT_W       = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic op,
   output logic busy,
   output logic hilo_we
);

   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

   muldiv_state_t    state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   // state and countdown registers, reset abandons any operation
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // next state: a start outside IDLE is ignored
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = BUSY;
               cnt_nx   = op ? DIV_LD : MULT_LD;
            end
         end
         BUSY: begin
            if (cnt == '0)
               state_nx = DONE;
            else
               cnt_nx = cnt - CNT_W'(1);
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy    = (state != IDLE);
   assign hilo_we = (state == DONE);

endmodule

// File: rtl/hazard_controller.sv
// Central pipeline control: forwarding, load-use and mult/div
// stalls, branch flushes. Optional HAZARD_STALL_CNT_EN adds stall_cnt.
module hazard_controller
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 16,
   parameter int CNT_W       = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] Drs1,
   input  logic [3:0] Drs2,
   input  logic       Dmuldiv,
   input  logic       Dhilo_rd,
   input  logic [3:0] Ers1,
   input  logic [3:0] Ers2,
   input  logic [3:0] Ewriteadd,
   input  logic       Ewe3,
   input  logic [1:0] Eregdata,
   input  logic       Emuldiv_start,
   input  logic       Emuldiv_op,
   input  logic       Ebranch_taken,
   input  logic [3:0] Mwriteadd,
   input  logic       Mwe3,
   input  logic [3:0] Wwriteadd,
   input  logic       Wwe3,
   output logic       Fstall,
   output logic       Dstall,
   output logic       Dflush,
   output logic       Eflush,
   output logic [1:0] Efwd1,
   output logic [1:0] Efwd2,
   output logic       muldiv_busy,
   output logic       hilo_we
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [15:0] stall_cnt
`endif
);

   logic lu, md, stall;
   logic sel_fl, sel_st;

   muldiv_sequencer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_seq (
      .clk     (clk),
      .rst     (rst),
      .start   (Emuldiv_start),
      .op      (Emuldiv_op),
      .busy    (muldiv_busy),
      .hilo_we (hilo_we)
   );

   assign lu = Ewe3 && (Eregdata == REGDATA_MEM)
            && (Ewriteadd != 4'd0)
            && ((Ewriteadd == Drs1) || (Ewriteadd == Drs2));
   assign md = muldiv_busy && (Dmuldiv || Dhilo_rd);
   assign stall = (lu || md) && !Ebranch_taken;

   assign sel_fl = rst || Ebranch_taken;
   assign sel_st = !sel_fl && stall;

   // pipeline register control: reset/branch flush beats stall
   always_comb begin
      Fstall = 1'b0;
      Dstall = 1'b0;
      Dflush = 1'b0;
      Eflush = 1'b0;
      unique case (1'b1)
         sel_fl: begin
            Dflush = 1'b1;
            Eflush = 1'b1;
         end
         sel_st: begin
            Fstall = 1'b1;
            Dstall = 1'b1;
            Eflush = 1'b1;
         end
         default: ;
      endcase
   end

   // E-stage operand selects, M result wins over W
   always_comb begin
      Efwd1 = FWD_RF;
      Efwd2 = FWD_RF;
      if (!rst) begin
         Efwd1 = fwd_sel(Ers1, Mwe3, Mwriteadd, Wwe3, Wwriteadd);
         Efwd2 = fwd_sel(Ers2, Mwe3, Mwriteadd, Wwe3, Wwriteadd);
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   // saturating count of cycles with the PC held
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (Fstall && stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central pipeline control unit for the 16-bit, 5-stage core.
- Computes E-stage operand forwarding selects, load-use stalls, taken-branch flushes and the multi-cycle mult/div sequencing that owns hi/lo writeback.
- Drives the stall/flush inputs of the F, D and E pipeline registers, and the hi/lo write enable.
- Reads hazard information from the D, E, M and W stage fields.

Parameters:
- MULT_CYCLES, 4: busy cycles for a multiply (>=1).
- DIV_CYCLES, 16: busy cycles for a divide (>=1).
- CNT_W, 5: width of the mult/div countdown counter; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- Drs1, Drs2  in  4  D-stage source register addresses.
- Dmuldiv  in  1  D-stage instruction is a mult/div.
- Dhilo_rd  in  1  D-stage instruction reads hi or lo.
- Ers1, Ers2  in  4  E-stage source register addresses.
- Ewriteadd  in  4  E-stage RF destination.
- Ewe3  in  1  E-stage RF write enable.
- Eregdata  in  2  E-stage RF write-data select; REGDATA_MEM (2'b01) means load.
- Emuldiv_start  in  1  E-stage mult/div issue.
- Emuldiv_op  in  1  0 = multiply, 1 = divide.
- Ebranch_taken  in  1  branch resolved taken in E.
- Mwriteadd  in  4  M-stage RF destination.
- Mwe3  in  1  M-stage RF write enable.
- Wwriteadd  in  4  W-stage RF destination.
- Wwe3  in  1  W-stage RF write enable.
- Fstall  out  1  hold the PC.
- Dstall  out  1  hold the F/D register.
- Dflush  out  1  zero the F/D register.
- Eflush  out  1  insert a bubble into the D/E register.
- Efwd1, Efwd2  out  2  E-operand select: 00 = RF, 01 = W result, 10 = M result.
- muldiv_busy  out  1  mult/div in progress.
- hilo_we  out  1  one-cycle hi/lo write strobe.

Behaviour:
- Register 0 is hardwired zero; it never matches for forwarding or hazard detection.
- Forwarding (combinational), for Efwdn:
  - 10 if Mwe3 && Mwriteadd==Ersn && Ersn!=0;
  - else 01 if Wwe3 && Wwriteadd==Ersn && Ersn!=0;
  - else 00.
  - M has priority over W when both match.
- Load-use (combinational): lu = Ewe3 && Eregdata==REGDATA_MEM && Ewriteadd!=0 && (Ewriteadd==Drs1 || Ewriteadd==Drs2).
- Mult/div hazard: md = muldiv_busy && (Dmuldiv || Dhilo_rd).
- stall = (lu || md) && !Ebranch_taken. When stall: Fstall = Dstall = Eflush = 1.
- Ebranch_taken: Dflush = Eflush = 1 and Fstall = Dstall = 0. A branch overrides any stall.
- Mult/div FSM, states IDLE, BUSY, DONE:
  - IDLE: if Emuldiv_start, go to BUSY and load cnt = (op ? DIV_CYCLES : MULT_CYCLES) - 1.
  - BUSY: if cnt==0, go to DONE; else cnt--.
  - DONE: hilo_we = 1 for this cycle, then IDLE.
  - muldiv_busy = (state != IDLE). It is high for N+1 cycles, starting the cycle after the start edge.
  - Emuldiv_start outside IDLE cannot legally occur, because D is stalled while busy; it is ignored.
  - A branch or flush does not abort an in-flight mult/div.
- Reset, sampled at posedge with rst=1:
  - state = IDLE, cnt = 0; muldiv_busy = hilo_we = 0.
  - While rst is high: Fstall = Dstall = 0, Dflush = Eflush = 1, Efwd1 = Efwd2 = 00.
  - Reset mid-mult/div abandons the operation with no hilo_we.
- All outputs except muldiv_busy and hilo_we are combinational from the inputs (zero latency). muldiv_busy and hilo_we are decoded from registered state.

Optional Feature:
- HAZARD_STALL_CNT_EN defined:
  - Adds output stall_cnt [15:0], counting cycles with Fstall=1.
  - Saturates at 16'hFFFF; cleared by rst.
- HAZARD_STALL_CNT_EN undefined:
  - Neither the port nor the counter exists.
  - All other behaviour is identical.

Decomposition:
- hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - REGDATA_MEM = 2'b01.
  - muldiv_state_t enum: IDLE, BUSY, DONE.
- One sub-module, muldiv_sequencer, containing the FSM and counter.
  - Inputs: clk, rst, start, op.
  - Outputs: busy, hilo_we.

Test Plan:
- Forwarding: Ers1=3, Mwe3=1, Mwriteadd=3, Wwe3=1, Wwriteadd=3 -> Efwd1=10. With Mwe3=0 -> Efwd1=01. With Ers1=0 under the same writes -> Efwd1=00.
- Load-use: Eregdata=01, Ewe3=1, Ewriteadd=5, Drs2=5 -> Fstall=Dstall=Eflush=1 for exactly that cycle. With Eregdata=00 -> no stall.
- Branch overrides stall: load-use condition plus Ebranch_taken=1 -> Dflush=Eflush=1, Fstall=Dstall=0.
- Multiply: Emuldiv_start=1, op=0 at edge k -> muldiv_busy high for cycles k+1..k+5, hilo_we=1 only in cycle k+5. Dhilo_rd=1 throughout -> Fstall=1 for cycles k+1..k+5, 0 at k+6.
- Divide with reset: start, op=1; rst=1 at the 8th busy cycle -> next cycle busy=0, hilo_we never asserted. A subsequent divide gives busy for 17 cycles.
- With HAZARD_STALL_CNT_EN: 3 load-use stalls plus one 5-cycle mult/div stall -> stall_cnt=8. Counter preloaded near saturation -> holds at 16'hFFFF.
